zip_dbl_prefetch: RTL and testbench
===================================

// Module: zip_dbl_prefetch
// PURPOSE
//  CPU-facing instruction prefetch: Wishbone B4 pipelined master fetching
//  32-bit words, up to 2 outstanding, into 2-entry buffer; presents
//  o_valid/o_insn/o_pc/o_illegal to CPU decode under i_ready handshake.
//  Sits between CPU front end and instruction bus/arbiter.
// PARAMETERS
//  ADDRESS_WIDTH  30  word-address bits; byte PC is ADDRESS_WIDTH+2 bits
// PORTS
//  i_clk          in   1     clock
//  i_reset        in   1     sync active-high reset
//  i_new_pc       in   1     redirect fetch to i_pc
//  i_clear_cache  in   1     flush all state; i_new_pc follows
//  i_ready        in   1     CPU accepts current instruction
//  i_pc           in   AW+2  byte address for redirect
//  o_valid        out  1     instruction/illegal valid
//  o_insn         out  32    instruction word
//  o_pc           out  AW+2  byte address of o_insn
//  o_illegal      out  1     fetch bus error (sticky)
//  o_wb_cyc/o_wb_stb/o_wb_we out 1 ; o_wb_addr out AW ; o_wb_data out 32
//  i_wb_stall/i_wb_ack/i_wb_err in 1 ; i_wb_data in 32
// BEHAVIOUR
//  Reset: o_valid=0, o_illegal=0, cyc=stb=0, o_wb_we=0, o_wb_data=0,
//   buffer empty, state IDLE; o_pc/o_insn/o_wb_addr undefined-but-held.
//  i_clear_cache == reset for all state; no fetch until next i_new_pc.
//  States: IDLE (no cyc), FETCH (cyc=1), ILLEGAL (cyc=0, sticky error).
//  IDLE->FETCH: cycle after i_new_pc; o_wb_addr=i_pc[AW+1:2], stb=1.
//  FETCH: stb issued when !stall and outstanding+buffered<2; addr+1 per
//   accepted stb (wraps modulo 2^AW). Drop cyc when outstanding==0 and
//   buffer full; re-raise when a slot frees (FETCH->IDLE->FETCH, no gap
//   required beyond 1 cycle).
//  Ack: word pushed to buffer; visible on o_valid one cycle after ack.
//  Latency: i_new_pc@0 -> stb@1; ack@k -> o_valid@k+1.
//  Handshake: o_valid&&!i_ready holds o_valid,o_pc,o_insn,o_illegal stable.
//   o_valid&&i_ready pops; next buffered word shown same-next cycle.
//  o_pc: first word after redirect = i_pc (low 2 bits preserved);
//   each pop: o_pc[AW+1:2]+=1, o_pc[1:0]=0.
//  i_wb_err: cyc=stb=0 next cycle; -> ILLEGAL; after buffered words
//   drain, o_valid=1,o_illegal=1 at next PC, held until new_pc/clear/reset.
//   o_illegal never rises without o_valid.
//  i_new_pc (any state, even with ack/err same cycle): o_valid=0,
//   o_illegal=0, buffer cleared, cyc dropped next cycle (abort), any
//   in-flight ack/err ignored; new fetch stb@+1 cycle after abort.
//  i_new_pc and i_ready same cycle: redirect wins; no pop.
//  Reset mid-bus-cycle: cyc=0 next cycle, late acks ignored.
//  o_illegal never clears except via reset/clear/new_pc.
// CONFIGURATION
//  ZIP_PF_MISALIGN_TRAP_EN defined: i_new_pc with i_pc[1:0]!=0 issues no
//   bus cycle; next cycle o_valid=1,o_illegal=1,o_pc=i_pc (ILLEGAL).
//  Undefined: low bits ignored for addressing, passed through on o_pc.
// TESTING
//  1 reset, new_pc=0x100, ack@1-cycle latency, i_ready=1 -> o_pc 0x100,
//    0x104,0x108 one per cycle; never >2 outstanding.
//  2 i_ready=0 5 cycles with o_valid -> o_insn/o_pc stable, cyc drops
//    once 2 buffered; on ready, 0x104 follows 0x100 next cycle.
//  3 err on 2nd fetch at 0x200 -> 0x200 valid, then o_illegal=1 at
//    0x204 held 10 cycles, cyc=0, no further stb.
//  4 new_pc=0x400 while 2 acks pending -> stale acks dropped; first
//    o_pc=0x400 with word from addr 0x100.
//  5 clear_cache during FETCH -> o_valid=0, cyc=0 until new_pc.
//  6 new_pc=0x302: macro on -> illegal@0x302, no cyc; off -> o_pc 0x302
//    then 0x304.

Source files
------------

// File: rtl/zip_dbl_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : zip_dbl_prefetch
// Description : Two-deep instruction prefetch. It is a Wishbone B4 pipelined
//               master that feeds CPU decode through an i_ready handshake.
//               Optional macro: ZIP_PF_MISALIGN_TRAP_EN (trap a misaligned
//               redirect).
// Revision    : 1.0 - initial release
// ============================================================================
module zip_dbl_prefetch #(
  parameter int ADDRESS_WIDTH = 30
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_new_pc,
  input  logic                     i_clear_cache,
  input  logic                     i_ready,
  input  logic [ADDRESS_WIDTH+1:0] i_pc,
  output logic                     o_valid,
  output logic [31:0]              o_insn,
  output logic [ADDRESS_WIDTH+1:0] o_pc,
  output logic                     o_illegal,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  output logic                     o_wb_we,
  output logic [ADDRESS_WIDTH-1:0] o_wb_addr,
  output logic [31:0]              o_wb_data,
  input  logic                     i_wb_stall,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_err,
  input  logic [31:0]              i_wb_data
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_ILLEGAL = 2'd2
  } state_t;

  state_t                   r_state, w_state_n;
  logic                     r_armed, w_armed_n;
  logic [1:0]               r_out, w_out_n;
  logic [1:0]               r_cnt, w_cnt_n;
  logic                     r_rd, r_wr;
  logic [31:0]              r_buf [2];
  logic [ADDRESS_WIDTH-1:0] r_wb_addr;
  logic [ADDRESS_WIDTH+1:0] r_pc;
  logic                     w_pop, w_accept, w_ack, w_err, w_room;
  logic [2:0]               w_used;

  assign w_pop    = (r_cnt != 2'd0) && i_ready && !i_new_pc;
  assign w_used   = {1'b0, r_out} + {1'b0, r_cnt};
  // A pop in this cycle frees a slot early enough to sustain one word per cycle.
  assign w_room   = (w_used < 3'd2) || ((w_used == 3'd2) && w_pop);
  assign o_wb_cyc = (r_state == S_FETCH);
  assign o_wb_stb = o_wb_cyc && w_room;
  assign w_accept = o_wb_stb && !i_wb_stall;
  assign w_ack    = o_wb_cyc && (r_out != 2'd0) && i_wb_ack && !i_wb_err;
  assign w_err    = o_wb_cyc && i_wb_err;

  always_comb begin
    w_state_n = r_state;
    w_armed_n = r_armed;
    w_out_n   = r_out + {1'b0, w_accept} - {1'b0, w_ack};
    w_cnt_n   = r_cnt + {1'b0, w_ack} - {1'b0, w_pop};
    if (i_new_pc) begin
      w_out_n   = 2'd0;
      w_cnt_n   = 2'd0;
      w_armed_n = 1'b1;
      // An open bus cycle is aborted first so that stale acks can't land.
      w_state_n = o_wb_cyc ? S_IDLE : S_FETCH;
`ifdef ZIP_PF_MISALIGN_TRAP_EN
      if (i_pc[1:0] != 2'b00) begin
        w_state_n = S_ILLEGAL;
        w_armed_n = 1'b0;
      end
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_armed && (w_cnt_n != 2'd2))
            w_state_n = S_FETCH;
        end
        S_FETCH: begin
          if (w_err) begin
            w_state_n = S_ILLEGAL;
            w_out_n   = 2'd0;
            w_armed_n = 1'b0;
          end else if ((w_out_n == 2'd0) && (w_cnt_n == 2'd2)) begin
            w_state_n = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear_cache) begin
      r_state   <= S_IDLE;
      r_armed   <= 1'b0;
      r_out     <= 2'd0;
      r_cnt     <= 2'd0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_wb_addr <= '0;
      r_pc      <= '0;
    end else begin
      r_state <= w_state_n;
      r_armed <= w_armed_n;
      r_out   <= w_out_n;
      r_cnt   <= w_cnt_n;
      if (i_new_pc) begin
        r_rd      <= 1'b0;
        r_wr      <= 1'b0;
        r_wb_addr <= i_pc[ADDRESS_WIDTH+1:2];
        r_pc      <= i_pc;
      end else begin
        if (w_accept)
          r_wb_addr <= r_wb_addr + ADDRESS_WIDTH'(1);
        if (w_ack)
          r_wr <= ~r_wr;
        if (w_pop) begin
          r_rd <= ~r_rd;
          r_pc <= {r_pc[ADDRESS_WIDTH+1:2] + ADDRESS_WIDTH'(1), 2'b00};
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_ack && !i_new_pc)
      r_buf[r_wr] <= i_wb_data;
  end

  assign o_valid   = (r_cnt != 2'd0) || (r_state == S_ILLEGAL);
  assign o_illegal = (r_state == S_ILLEGAL) && (r_cnt == 2'd0);
  assign o_insn    = r_buf[r_rd];
  assign o_pc      = r_pc;
  assign o_wb_addr = r_wb_addr;
  assign o_wb_we   = 1'b0;
  assign o_wb_data = 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_zip_dbl_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_zip_dbl_prefetch
// Description : Randomised bench for zip_dbl_prefetch. It includes a stalling
//               and erroring Wishbone slave and an in-order stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zip_dbl_prefetch;

  logic        i_clk = 1'b0;
  logic        i_reset, i_new_pc, i_clear_cache, i_ready;
  logic [31:0] i_pc;
  logic        o_valid, o_illegal, o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_insn, o_pc, o_wb_data;
  logic [29:0] o_wb_addr;
  logic        i_wb_stall, i_wb_ack, i_wb_err;
  logic [31:0] i_wb_data;

  always #5 i_clk = ~i_clk;

  zip_dbl_prefetch #(.ADDRESS_WIDTH(30)) u_dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_new_pc(i_new_pc),
    .i_clear_cache(i_clear_cache), .i_ready(i_ready), .i_pc(i_pc),
    .o_valid(o_valid), .o_insn(o_insn), .o_pc(o_pc), .o_illegal(o_illegal),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .i_wb_stall(i_wb_stall),
    .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return ({2'b00, a} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Stimulus controls
  int          ready_pct = 100, stall_pct = 0, ack_pct = 100, late_pct = 0;
  logic        q_newpc = 1'b0, q_clear = 1'b0, q_rst = 1'b0;
  logic [31:0] q_pc = '0;
  logic        err_en = 1'b0;
  logic [29:0] err_word = '0;

  // Reference model: expected next instruction PC, next request address, error site
  logic        active = 1'b0;
  logic [31:0] exp_pc = '0;
  logic [29:0] exp_req = '0;
  logic        hit = 1'b0;
  logic [29:0] hit_word = '0;
  logic [29:0] pend[$];
  logic        hold = 1'b0, h_ill = 1'b0;
  logic [31:0] h_pc = '0, h_insn = '0;
  int          cyc_n = 0, pops = 0, stb_cnt = 0, first_ack = -1, first_val = -1;

  task automatic tick();
    logic pop, acked, erred;
    @(negedge i_clk);
    cyc_n++;
    if (hold) begin
      check_eq("hold_valid", o_valid, 1);
      check_eq("hold_pc", o_pc, h_pc);
      check_eq("hold_insn", o_insn, h_insn);
      check_eq("hold_illegal", o_illegal, h_ill);
    end
    if (!active) check_eq("idle_valid", o_valid, 0);
    check_eq("illegal_without_valid", o_illegal && !o_valid, 0);
    if (o_illegal) begin
      check_eq("illegal_expected", hit, 1);
      check_eq("illegal_pc", o_pc, exp_pc);
      check_eq("illegal_word", o_pc[31:2], hit_word);
    end
    if (hit) check_eq("cyc_after_error", o_wb_cyc, 0);
    if (o_valid && first_val < 0) first_val = cyc_n;

    i_reset       = q_rst;
    i_clear_cache = q_clear;
    i_new_pc      = q_newpc;
    i_pc          = q_pc;
    q_rst = 1'b0; q_clear = 1'b0; q_newpc = 1'b0;
    i_ready    = ($urandom_range(99) < ready_pct);
    i_wb_stall = ($urandom_range(99) < stall_pct);
    i_wb_ack   = 1'b0;
    i_wb_err   = 1'b0;
    i_wb_data  = $urandom;
    acked = 1'b0;
    erred = 1'b0;
    if (!o_wb_cyc) begin
      pend.delete();
      if ($urandom_range(99) < late_pct) i_wb_ack = 1'b1;
    end else if (pend.size() > 0 && $urandom_range(99) < ack_pct) begin
      if (err_en && pend[0] == err_word) begin
        i_wb_err = 1'b1;
        erred    = 1'b1;
      end else begin
        i_wb_ack  = 1'b1;
        i_wb_data = mem_word(pend[0]);
        acked     = 1'b1;
      end
      void'(pend.pop_front());
    end
    #1;
    pop = o_valid && !o_illegal && i_ready && !i_new_pc && !i_clear_cache && !i_reset;
    if (pop) begin
      check_eq("pc", o_pc, exp_pc);
      check_eq("insn", o_insn, mem_word(exp_pc[31:2]));
      exp_pc = {exp_pc[31:2] + 30'd1, 2'b00};
      pops++;
    end
    check_eq("stb_without_cyc", o_wb_stb && !o_wb_cyc, 0);
    if (!active || hit) check_eq("unexpected_stb", o_wb_stb, 0);
    if (o_wb_stb && !i_wb_stall) begin
      check_eq("req_addr", o_wb_addr, exp_req);
      exp_req++;
      pend.push_back(o_wb_addr);
      stb_cnt++;
      check_eq("max_outstanding", pend.size() <= 2, 1);
    end
    if (acked && first_ack < 0 && !i_new_pc) first_ack = cyc_n;
    hold   = o_valid && !i_ready && !i_new_pc && !i_clear_cache && !i_reset;
    h_pc   = o_pc;
    h_insn = o_insn;
    h_ill  = o_illegal;

    if (i_reset || i_clear_cache) begin
      active = 1'b0;
      hit    = 1'b0;
    end else if (i_new_pc) begin
      active    = 1'b1;
      exp_pc    = i_pc;
      exp_req   = i_pc[31:2];
      hit       = 1'b0;
      first_ack = -1;
      first_val = -1;
`ifdef ZIP_PF_MISALIGN_TRAP_EN
      if (i_pc[1:0] != 2'b00) begin
        hit      = 1'b1;
        hit_word = i_pc[31:2];
      end
`endif
    end else if (erred) begin
      hit      = 1'b1;
      hit_word = err_word;
    end
  endtask

  task automatic newpc(input logic [31:0] v);
    q_newpc = 1'b1;
    q_pc    = v;
    tick();
  endtask

  task automatic wait_valid(input string tag);
    for (int k = 0; k < 30 && !o_valid; k++) tick();
    check_eq(tag, o_valid, 1);
  endtask

  initial begin
    int p0, s0, r;
    i_reset = 1'b1; i_new_pc = 1'b0; i_clear_cache = 1'b0; i_ready = 1'b0;
    i_pc = '0; i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_data = '0;
    repeat (2) @(negedge i_clk);
    check_eq("rst_valid", o_valid, 0);
    check_eq("rst_illegal", o_illegal, 0);
    check_eq("rst_cyc", o_wb_cyc, 0);
    check_eq("rst_stb", o_wb_stb, 0);
    check_eq("rst_we", o_wb_we, 0);
    check_eq("rst_wdata", o_wb_data, 0);

    // Streaming at full rate
    newpc(32'h100);
    tick();
    check_eq("t1_stb", o_wb_stb, 1);
    check_eq("t1_cyc", o_wb_cyc, 1);
    check_eq("t1_addr", o_wb_addr, 30'h40);
    repeat (4) tick();
    check_eq("t1_ack_to_valid", first_val - first_ack, 1);
    p0 = pops;
    repeat (10) tick();
    check_eq("t1_rate", pops - p0, 10);

    // Back-pressure
    ready_pct = 0;
    newpc(32'h100);
    repeat (7) tick();
    check_eq("t2_cyc_dropped", o_wb_cyc, 0);
    check_eq("t2_valid", o_valid, 1);
    check_eq("t2_pc", o_pc, 32'h100);
    ready_pct = 100;
    tick();
    tick();
    check_eq("t2_next_pc", o_pc, 32'h104);
    repeat (5) tick();

    // Bus error on the second fetch
    err_en = 1'b1;
    err_word = 30'h81;
    newpc(32'h200);
    repeat (8) tick();
    check_eq("t3_illegal", o_illegal, 1);
    check_eq("t3_pc", o_pc, 32'h204);
    s0 = stb_cnt;
    repeat (10) tick();
    check_eq("t3_illegal_held", o_illegal && o_valid, 1);
    check_eq("t3_pc_held", o_pc, 32'h204);
    check_eq("t3_no_stb", stb_cnt - s0, 0);
    check_eq("t3_cyc", o_wb_cyc, 0);
    err_en = 1'b0;

    // Redirect with two acks pending
    ack_pct = 0;
    newpc(32'h100);
    for (int k = 0; k < 20 && pend.size() < 2; k++) tick();
    check_eq("t4_pending", pend.size(), 2);
    ack_pct = 100;
    late_pct = 100;
    newpc(32'h400);
    wait_valid("t4_valid_timeout");
    check_eq("t4_first_pc", o_pc, 32'h400);
    check_eq("t4_first_insn", o_insn, mem_word(30'h100));
    late_pct = 0;
    repeat (5) tick();

    // Flush mid-fetch
    newpc(32'h500);
    repeat (3) tick();
    q_clear = 1'b1;
    tick();
    repeat (8) tick();
    check_eq("t5_cyc", o_wb_cyc, 0);
    check_eq("t5_valid", o_valid, 0);

    // Misaligned redirect
    newpc(32'h302);
    wait_valid("t6_valid_timeout");
    check_eq("t6_pc", o_pc, 32'h302);
`ifdef ZIP_PF_MISALIGN_TRAP_EN
    check_eq("t6_illegal", o_illegal, 1);
    check_eq("t6_cyc", o_wb_cyc, 0);
`else
    check_eq("t6_illegal", o_illegal, 0);
    check_eq("t6_insn", o_insn, mem_word(30'hC0));
    tick();
    wait_valid("t6_second_timeout");
    check_eq("t6_second_pc", o_pc, 32'h304);
`endif
    repeat (3) tick();

    // Randomised traffic
    for (int n = 0; n < 4000; n++) begin
      if (n % 200 == 0) begin
        ready_pct = $urandom_range(100, 30);
        stall_pct = $urandom_range(50);
        ack_pct   = $urandom_range(100, 30);
        late_pct  = $urandom_range(50);
      end
      r = $urandom_range(999);
      if (r < 15 || !active) begin
        if (r < 15 || $urandom_range(9) == 0) begin
          q_newpc = 1'b1;
          q_pc = $urandom & 32'hFFFF_FFFC;
          if ($urandom_range(3) == 0) q_pc[1:0] = 2'($urandom_range(3));
          err_en = ($urandom_range(3) == 0);
          err_word = q_pc[31:2] + 30'($urandom_range(5));
        end
      end else if (r < 18) begin
        q_clear = 1'b1;
      end else if (r < 20) begin
        q_rst = 1'b1;
      end
      tick();
    end
    check_eq("progress", pops > 200, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
